// File: rtl/snn_pkg.sv
// Shared types and constants for the parametrised SNN inference core.
package snn_pkg;

    typedef enum logic [3:0] {
        IDLE, L1_MAC, L1_DRAIN, L1_LUT, L1_WR,
        L2_MAC, L2_DRAIN, L2_LUT, L2_CMP, DONE
    } snn_state_t;

    // Wide enough that the worst-case sum of products can never wrap.
    function automatic int acc_width(int w, int n_in, int n_hid);
        return 2 * w + $clog2((n_in > n_hid) ? n_in : n_hid);
    endfunction

    // Bias that maps the signed clamped accumulator onto an unsigned LUT address.
    function automatic int lut_off(int aw);
        return 2 ** (aw - 1);
    endfunction

endpackage

// File: rtl/snn_mac.sv
// Signed multiply-accumulate with synchronous clear and a LUT_AW-bit clamped view.
// SNN_SAT_FLAG_EN exposes the clamp indication as a port.
module snn_mac import snn_pkg::*; #(
    parameter int W      = 8,
    parameter int AW     = 26,
    parameter int LUT_AW = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic [LUT_AW-1:0] sat_val
`ifdef SNN_SAT_FLAG_EN
    ,
    output logic              sat
`endif
);
    localparam int HI = 2 ** (LUT_AW - 1) - 1;
    localparam logic signed [AW-1:0] ACC_HI = AW'(HI);
    localparam logic signed [AW-1:0] ACC_LO = AW'(-HI - 1);

    logic signed [AW-1:0]    acc;
    logic signed [2*W-1:0]   prod;
    logic                    over, under;

    assign prod = $signed(a) * $signed(b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + {{(AW-2*W){prod[2*W-1]}}, prod};
    end

    assign over    = acc > ACC_HI;
    assign under   = acc < ACC_LO;
    assign sat_val = over  ? {1'b0, {(LUT_AW-1){1'b1}}} :
                     under ? {1'b1, {(LUT_AW-1){1'b0}}} : acc[LUT_AW-1:0];
`ifdef SNN_SAT_FLAG_EN
    assign sat = over | under;
`endif

endmodule

// File: rtl/snn_core_param.sv
// Two-layer binary-input SNN inference core with external weight ROMs and LUT.
// SNN_SAT_FLAG_EN adds a sticky sat_flag output for accumulator clamping.
module snn_core_param import snn_pkg::*; #(
    parameter int N_IN   = 784,
    parameter int N_HID  = 32,
    parameter int N_OUT  = 10,
    parameter int W      = 8,
    parameter int LUT_AW = 11
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             q_input,
    output logic [$clog2(N_IN)-1:0]          addr_input_unit,
    output logic [$clog2(N_HID)+$clog2(N_IN)-1:0] hw_addr,
    input  logic [W-1:0]                     hw_q,
    output logic [$clog2(N_OUT)+$clog2(N_HID)-1:0] ow_addr,
    input  logic [W-1:0]                     ow_q,
    output logic [LUT_AW-1:0]                lut_addr,
    input  logic [W-1:0]                     lut_q,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(N_OUT)-1:0]         digit,
    output logic [W-1:0]                     score
`ifdef SNN_SAT_FLAG_EN
    ,
    output logic                             sat_flag
`endif
);
    localparam int IW = $clog2(N_IN);
    localparam int HW = $clog2(N_HID);
    localparam int OW = $clog2(N_OUT);
    localparam int CW = (IW > HW) ? IW : HW;
    localparam int NW = (HW > OW) ? HW : OW;
    localparam int AW = acc_width(W, N_IN, N_HID);

    snn_state_t        state;
    logic [CW-1:0]     count;
    logic [NW-1:0]     node;
    logic [W-1:0]      best_val;
    logic [OW-1:0]     best_idx;
    logic [W-1:0]      hid_q;
    logic [W-1:0]      hidden_ram [N_HID];
    logic              mac_vld;
    logic              issue, l2_op, lut_phase, mac_clr;
    logic [W-1:0]      op_a, op_b;
    logic [LUT_AW-1:0] sat_val;
`ifdef SNN_SAT_FLAG_EN
    logic              mac_sat;
`endif

    assign issue     = (state == L1_MAC) || (state == L2_MAC);
    assign l2_op     = (state == L2_MAC) || (state == L2_DRAIN);
    assign lut_phase = (state == L1_LUT) || (state == L2_LUT);
    assign mac_clr   = (state == IDLE) || (state == L1_WR) || (state == L2_CMP);

    // A set pixel contributes the largest positive W-bit value.
    assign op_a = l2_op ? hid_q : (q_input ? {1'b0, {(W-1){1'b1}}} : '0);
    assign op_b = l2_op ? ow_q : hw_q;

    assign addr_input_unit = count[IW-1:0];
    assign hw_addr         = {node[HW-1:0], count[IW-1:0]};
    assign ow_addr         = {node[OW-1:0], count[HW-1:0]};
    assign lut_addr        = lut_phase ? sat_val + LUT_AW'(lut_off(LUT_AW)) : '0;

    snn_mac #(.W(W), .AW(AW), .LUT_AW(LUT_AW)) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (mac_clr),
        .en      (mac_vld),
        .a       (op_a),
        .b       (op_b),
        .sat_val (sat_val)
`ifdef SNN_SAT_FLAG_EN
        ,
        .sat     (mac_sat)
`endif
    );

    always_ff @(posedge clk) begin
        if (state == L1_WR)
            hidden_ram[node[HW-1:0]] <= lut_q;
        if (state == L2_MAC)
            hid_q <= hidden_ram[count[HW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            node     <= '0;
            best_val <= '0;
            best_idx <= '0;
            mac_vld  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            digit    <= '0;
            score    <= '0;
        end else begin
            mac_vld <= issue;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    count    <= '0;
                    node     <= '0;
                    best_val <= '0;
                    best_idx <= '0;
                    if (start) begin
                        busy  <= 1'b1;
                        state <= L1_MAC;
                    end
                end
                L1_MAC: begin
                    if (count == CW'(N_IN - 1)) state <= L1_DRAIN;
                    else count <= count + CW'(1);
                end
                L1_DRAIN: state <= L1_LUT;
                L1_LUT:   state <= L1_WR;
                L1_WR: begin
                    count <= '0;
                    if (node == NW'(N_HID - 1)) begin
                        node  <= '0;
                        state <= L2_MAC;
                    end else begin
                        node  <= node + NW'(1);
                        state <= L1_MAC;
                    end
                end
                L2_MAC: begin
                    if (count == CW'(N_HID - 1)) state <= L2_DRAIN;
                    else count <= count + CW'(1);
                end
                L2_DRAIN: state <= L2_LUT;
                L2_LUT:   state <= L2_CMP;
                L2_CMP: begin
                    count <= '0;
                    // Strict compare so ties keep the lower class index.
                    if (node == '0 || $signed(lut_q) > $signed(best_val)) begin
                        best_val <= lut_q;
                        best_idx <= node[OW-1:0];
                    end
                    if (node == NW'(N_OUT - 1)) begin
                        state <= DONE;
                    end else begin
                        node  <= node + NW'(1);
                        state <= L2_MAC;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    digit <= best_idx;
                    score <= best_val;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SNN_SAT_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_flag <= 1'b0;
        else if (state == IDLE && start)
            sat_flag <= 1'b0;
        else if (lut_phase && mac_sat)
            sat_flag <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_snn_core_param.sv
// Bench for snn_core_param: small 4-2-3 instance with a reference model and
// scoreboard, plus a default-size instance driven into accumulator saturation.
module tb_snn_core_param;
    localparam int N_IN = 4, N_HID = 2, N_OUT = 3, W = 8, LUT_AW = 11;
    localparam int IW = 2, HW = 1, OW = 2;
    localparam int DIW = 10, DHW = 5, DOW = 4;

    typedef struct {
        logic [OW-1:0]     digit;
        logic [W-1:0]      score;
        logic              sat;
        logic [LUT_AW-1:0] lut1;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 start, q_input, busy, done;
    logic [IW-1:0]        addr_input_unit;
    logic [HW+IW-1:0]     hw_addr;
    logic [OW+HW-1:0]     ow_addr;
    logic [W-1:0]         hw_q, ow_q, lut_q, score;
    logic [LUT_AW-1:0]    lut_addr;
    logic [OW-1:0]        digit;
    logic                 sat_flag, d_sat_flag;

    logic                 d_start, d_q_input, d_busy, d_done;
    logic [DIW-1:0]       d_addr_input_unit;
    logic [DHW+DIW-1:0]   d_hw_addr;
    logic [DOW+DHW-1:0]   d_ow_addr;
    logic [W-1:0]         d_hw_q, d_ow_q, d_lut_q, d_score;
    logic [LUT_AW-1:0]    d_lut_addr;
    logic [DOW-1:0]       d_digit;

    logic [W-1:0] hw_rom [0:7];
    logic [W-1:0] ow_rom [0:7];
    logic         pix    [0:N_IN-1];
    exp_t         sbq [$];
    int           n_cmp = 0, n_err = 0;

`ifndef SNN_SAT_FLAG_EN
    assign sat_flag   = 1'b0;
    assign d_sat_flag = 1'b0;
`endif

    snn_core_param #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .W(W), .LUT_AW(LUT_AW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .q_input(q_input),
        .addr_input_unit(addr_input_unit), .hw_addr(hw_addr), .hw_q(hw_q),
        .ow_addr(ow_addr), .ow_q(ow_q), .lut_addr(lut_addr), .lut_q(lut_q),
        .busy(busy), .done(done), .digit(digit), .score(score)
`ifdef SNN_SAT_FLAG_EN
        , .sat_flag(sat_flag)
`endif
    );

    snn_core_param u_dflt (
        .clk(clk), .rst(rst), .start(d_start), .q_input(d_q_input),
        .addr_input_unit(d_addr_input_unit), .hw_addr(d_hw_addr), .hw_q(d_hw_q),
        .ow_addr(d_ow_addr), .ow_q(d_ow_q), .lut_addr(d_lut_addr), .lut_q(d_lut_q),
        .busy(d_busy), .done(d_done), .digit(d_digit), .score(d_score)
`ifdef SNN_SAT_FLAG_EN
        , .sat_flag(d_sat_flag)
`endif
    );

    function automatic logic [W-1:0] lutf(logic [LUT_AW-1:0] a);
        int v;
        v = int'(a) - 1024;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return W'(v);
    endfunction

    function automatic logic [LUT_AW-1:0] sat_addr(int acc);
        int c;
        c = acc;
        if (c > 1023) c = 1023;
        if (c < -1024) c = -1024;
        return LUT_AW'(c + 1024);
    endfunction

    // Synchronous-read memories seen by the two instances.
    always @(posedge clk) begin
        q_input   <= pix[addr_input_unit];
        hw_q      <= hw_rom[hw_addr];
        ow_q      <= ow_rom[ow_addr];
        lut_q     <= lutf(lut_addr);
        d_q_input <= 1'b1;
        d_hw_q    <= 8'd127;
        d_ow_q    <= 8'd127;
        d_lut_q   <= lutf(d_lut_addr);
    end

    function automatic exp_t model();
        exp_t e;
        int hid [N_HID];
        int acc, v, best;
        e.sat = 1'b0; e.digit = '0; e.score = '0; e.lut1 = '0; best = 0;
        for (int h = 0; h < N_HID; h++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++)
                if (pix[i]) acc += 127 * int'($signed(hw_rom[h*N_IN+i]));
            if (acc > 1023 || acc < -1024) e.sat = 1'b1;
            if (h == 0) e.lut1 = sat_addr(acc);
            hid[h] = int'($signed(lutf(sat_addr(acc))));
        end
        for (int o = 0; o < N_OUT; o++) begin
            acc = 0;
            for (int k = 0; k < N_HID; k++)
                acc += hid[k] * int'($signed(ow_rom[o*N_HID+k]));
            if (acc > 1023 || acc < -1024) e.sat = 1'b1;
            v = int'($signed(lutf(sat_addr(acc))));
            if (o == 0 || v > best) begin
                best = v; e.digit = OW'(o); e.score = W'(v);
            end
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic kick(bit push, bit hold);
        if (push) sbq.push_back(model());
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(string tag, int exp_lat);
        int n;
        bit busy_ok;
        logic [LUT_AW-1:0] first_lut;
        exp_t e;
        n = 0; busy_ok = 1'b1; first_lut = '0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!done && !busy) busy_ok = 1'b0;
            if (first_lut == '0 && lut_addr != '0) first_lut = lut_addr;
        end while (!done && n < 200);
        chk({tag, "_done_seen"}, 32'(done), 1);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy"}, 32'(busy_ok), 1);
        e = sbq.pop_front();
        chk({tag, "_lut1"}, 32'(first_lut), 32'(e.lut1));
        chk({tag, "_digit"}, 32'(digit), 32'(e.digit));
        chk({tag, "_score"}, 32'(score), 32'(e.score));
`ifdef SNN_SAT_FLAG_EN
        chk({tag, "_sat"}, 32'(sat_flag), 32'(e.sat));
`endif
    endtask

    task automatic chk_idle_outputs(string tag);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_digit"}, 32'(digit), 0);
        chk({tag, "_score"}, 32'(score), 0);
        chk({tag, "_lut_addr"}, 32'(lut_addr), 0);
        chk({tag, "_addr_in"}, 32'(addr_input_unit), 0);
        chk({tag, "_hw_addr"}, 32'(hw_addr), 0);
        chk({tag, "_ow_addr"}, 32'(ow_addr), 0);
    endtask

    task automatic randomize_net();
        int r;
        for (int i = 0; i < N_IN; i++) pix[i] = 1'($urandom_range(1));
        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(4)) - 2; hw_rom[i] = r[7:0];
            r = int'($urandom_range(4)) - 2; ow_rom[i] = r[7:0];
        end
    endtask

    initial begin
        int n, pulses;
        logic [LUT_AW-1:0] first;
        rst = 1'b1; start = 1'b0; d_start = 1'b0;
        for (int i = 0; i < N_IN; i++) pix[i] = 1'b1;
        for (int i = 0; i < 8; i++) begin hw_rom[i] = 8'd1; ow_rom[i] = 8'd1; end
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_d_busy", 32'(d_busy), 0);
        chk("reset_d_done", 32'(d_done), 0);
        @(negedge clk) rst = 1'b0;

        // All ones: every class sum equal, lowest index wins.
        kick(1'b1, 1'b0); wait_done("ones", 30);

        ow_rom[0] = 8'hFF; ow_rom[1] = 8'hFF; ow_rom[2] = 8'd0; ow_rom[3] = 8'd0;
        ow_rom[4] = 8'd1;  ow_rom[5] = 8'd0;
        kick(1'b1, 1'b0); wait_done("cls2", 30);

        ow_rom[2] = 8'd1; ow_rom[3] = 8'd0;
        kick(1'b1, 1'b0); wait_done("tie12", 30);

        for (int i = 0; i < 8; i++) hw_rom[i] = 8'd3;
        kick(1'b1, 1'b0); wait_done("hsat", 30);

        for (int t = 0; t < 3; t++) begin
            randomize_net();
            kick(1'b1, 1'b0); wait_done("rand", 30);
        end

        // Abort an inference partway through.
        kick(1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_idle_outputs("midrst");
        @(negedge clk) rst = 1'b0;
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
        chk("midrst_no_done", pulses, 0);
        kick(1'b1, 1'b0); wait_done("after_rst", 30);

        // start held through DONE: second run accepted on the done cycle.
        sbq.push_back(model());
        kick(1'b1, 1'b1);
        wait_done("b2b_1", 30);
        wait_done("b2b_2", 31);
        start = 1'b0;
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
        chk("b2b_no_third", pulses, 0);

        // Default-size instance with every weight at 127.
        @(negedge clk) d_start = 1'b1;
        @(posedge clk);
        #1 d_start = 1'b0;
        n = 0; first = '0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (first == '0 && d_lut_addr != '0) first = d_lut_addr;
        end while (!d_done && n < 30000);
        chk("dflt_done_seen", 32'(d_done), 1);
        chk("dflt_latency", n, 1 + 32 * 787 + 10 * 35);
        chk("dflt_lut1", 32'(first), 2047);
        chk("dflt_digit", 32'(d_digit), 0);
        chk("dflt_score", 32'(d_score), 127);
`ifdef SNN_SAT_FLAG_EN
        chk("dflt_sat", 32'(d_sat_flag), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
